pwm_generator: RTL and testbench

- Consumes the five configuration bytes written over SPI and drives the 16 chip output pins.
- Per pin: forced low, static high, or PWM-modulated from one shared 8-bit duty cycle.
- A single prescaler and 8-bit period counter generate the PWM waveform.
- Duty changes are double-buffered and take effect only at a period boundary, so no glitches or runt pulses reach the pins.

---
 rtl/pwm_generator.sv | 52 +++++
 tb/tb_pwm_generator.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_generator.sv
// 16-pin PWM generator with a shared, period-buffered 8-bit duty cycle.
// Each pin is forced low, held high, or driven by the PWM level.
module pwm_generator #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] en_out,
  input  logic [15:0] en_pwm,
  input  logic [7:0]  duty,
  output logic [15:0] pwm_out,
  output logic        period_start
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] prescaler;
  logic [7:0]  cnt;
  logic [7:0]  duty_shadow;
  logic        tick;
  logic        wrap;
  logic        wrap_q;
  logic        lvl;
  logic [15:0] pins;

  assign tick = (prescaler == LAST);
  assign wrap = tick && (cnt == 8'hFF);

  // Full-scale duty must not drop for the cnt==255 step.
  assign lvl  = (duty_shadow == 8'hFF) || (cnt < duty_shadow);
  assign pins = en_out & (~en_pwm | {16{lvl}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler    <= '0;
      cnt          <= '0;
      duty_shadow  <= '0;
      wrap_q       <= 1'b0;
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 16'd1;
      if (tick) cnt <= cnt + 8'd1;
      if (wrap) duty_shadow <= duty;
      wrap_q  <= wrap;
      pwm_out <= pins;
      // Two stages so the pulse lines up with the first pin value of a period.
      period_start <= wrap_q;
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: PRESCALE=2 and PRESCALE=1 instances run side by
// side against a clock-index arithmetic model of the waveform.
module tb_pwm_generator;

  localparam int P [2] = '{2, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] en_out = '0;
  logic [15:0] en_pwm = '0;
  logic [7:0]  duty = '0;
  logic [15:0] pwm_out [2];
  logic        period_start [2];

  logic [15:0] exp_pwm [2];
  logic        exp_ps [2];
  int          n [2];
  logic [7:0]  shadow [2];
  int          hi [2];
  int          pidx [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_generator #(.PRESCALE(2)) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .duty         (duty),
    .pwm_out      (pwm_out[0]),
    .period_start (period_start[0])
  );

  pwm_generator #(.PRESCALE(1)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .duty         (duty),
    .pwm_out      (pwm_out[1]),
    .period_start (period_start[1])
  );

  // n = clocks since reset release; the pin after a clock shows clock n's state.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        n[g]       <= 0;
        shadow[g]  <= '0;
        exp_pwm[g] <= '0;
        exp_ps[g]  <= 1'b0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        automatic int per = P[g] * 256;
        automatic int step = (n[g] / P[g]) % 256;
        automatic logic lvl = (shadow[g] == 8'd255) || (step < int'(shadow[g]));
        automatic logic [15:0] pins = '0;
        for (int i = 0; i < 16; i++)
          if (en_out[i]) pins[i] = en_pwm[i] ? lvl : 1'b1;
        exp_pwm[g] <= pins;
        exp_ps[g]  <= (n[g] > 0) && (n[g] % per == 0);
        if (n[g] % per == per - 1) shadow[g] <= duty;
        n[g] <= n[g] + 1;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int g = 0; g < 2; g++) begin
      hi[g] = 0;
      pidx[g] = 0;
    end
  endtask

  task automatic test_reset();
    int last = -1;
    int pulses = 0;
    en_out = '0; en_pwm = '0; duty = '0;
    #1 rst_n = 1'b0;
    #12;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (pwm_out[g] !== 16'h0 || period_start[g] !== 1'b0) begin
        failures++;
        $display("FAIL reset_value dut%0d pwm=%h ps=%b want 0000/0", g,
                 pwm_out[g], period_start[g]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (pwm_out[g] !== exp_pwm[g] || period_start[g] !== exp_ps[g]) begin
          failures++;
          $display("FAIL reset_run dut%0d k=%0d pwm=%h ps=%b want %h/%b", g, k,
                   pwm_out[g], period_start[g], exp_pwm[g], exp_ps[g]);
        end
      end
      checks++;
      if (pwm_out[0] !== 16'h0) begin
        failures++;
        $display("FAIL reset_low k=%0d pwm=%h want 0000", k, pwm_out[0]);
      end
      if (period_start[0]) begin
        if (last >= 0) begin
          checks++;
          if (k - last != 512) begin
            failures++;
            $display("FAIL reset_spacing got=%0d want=512", k - last);
          end
        end
        last = k;
        pulses++;
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL reset_pulses got=%0d want=3", pulses);
    end
  endtask

  task automatic test_static();
    en_out = 16'h00FF; en_pwm = '0; duty = 8'($urandom);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (pwm_out[g] !== 16'h00FF || exp_pwm[g] !== 16'h00FF) begin
          failures++;
          $display("FAIL static_high dut%0d pwm=%h model=%h want 00ff", g,
                   pwm_out[g], exp_pwm[g]);
        end
      end
      duty = 8'($urandom);
    end
    en_out = 16'h00F7;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (pwm_out[g] !== 16'h00F7) begin
        failures++;
        $display("FAIL static_clear dut%0d pwm=%h want 00f7", g, pwm_out[g]);
      end
    end
    for (int k = 0; k < 40; k++) begin
      en_out = 16'($urandom); en_pwm = 16'($urandom); duty = 8'($urandom);
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (pwm_out[g] !== exp_pwm[g] || (pwm_out[g] & ~en_out) != 16'h0) begin
          failures++;
          $display("FAIL static_mux dut%0d pwm=%h want %h en=%h", g,
                   pwm_out[g], exp_pwm[g], en_out);
        end
      end
    end
  endtask

  task automatic test_duty_half();
    en_out = '1; en_pwm = '1; duty = 8'd128;
    do_reset();
    for (int k = 0; k < 3 * 512 + 8; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (pwm_out[g] !== exp_pwm[g] || period_start[g] !== exp_ps[g]) begin
          failures++;
          $display("FAIL half_run dut%0d k=%0d pwm=%h ps=%b want %h/%b", g, k,
                   pwm_out[g], period_start[g], exp_pwm[g], exp_ps[g]);
        end
        if (period_start[g]) begin
          checks++;
          if (hi[g] != (pidx[g] == 0 ? 0 : 128 * P[g])) begin
            failures++;
            $display("FAIL half_high dut%0d period=%0d got=%0d want=%0d", g,
                     pidx[g], hi[g], pidx[g] == 0 ? 0 : 128 * P[g]);
          end
          checks++;
          if (pwm_out[g] !== 16'hFFFF) begin
            failures++;
            $display("FAIL half_rise dut%0d pwm=%h want ffff", g, pwm_out[g]);
          end
          hi[g] = 0;
          pidx[g]++;
        end
        if (pwm_out[g][0]) hi[g]++;
      end
    end
    checks++;
    if (pidx[0] != 3 || pidx[1] != 6) begin
      failures++;
      $display("FAIL half_periods got=%0d/%0d want=3/6", pidx[0], pidx[1]);
    end
  endtask

  task automatic test_extremes();
    logic [7:0] dv [2] = '{8'd255, 8'd0};
    logic [15:0] lv [2] = '{16'hFFFF, 16'h0000};
    int seen;
    for (int t = 0; t < 2; t++) begin
      duty = dv[t];
      seen = 0;
      for (int k = 0; k < 4 * 512 + 8; k++) begin
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
          checks++;
          if (pwm_out[g] !== exp_pwm[g] || period_start[g] !== exp_ps[g]) begin
            failures++;
            $display("FAIL extreme_run dut%0d duty=%0d pwm=%h want %h", g,
                     dv[t], pwm_out[g], exp_pwm[g]);
          end
        end
        if (period_start[0]) seen++;
        if (seen > 0) begin
          checks++;
          if (pwm_out[0] !== lv[t]) begin
            failures++;
            $display("FAIL extreme_level duty=%0d pwm=%h want %h", dv[t],
                     pwm_out[0], lv[t]);
          end
        end
      end
      checks++;
      if (seen < 4) begin
        failures++;
        $display("FAIL extreme_periods got=%0d want>=4", seen);
      end
    end
  endtask

  task automatic test_mid_change();
    int want [2] = '{128, 384};
    int cnt_hi, edges, chg;
    logic prev, found;
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      found = period_start[0];
    end
    duty = 8'd64;
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      found = period_start[0];
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mid_sync no period_start within 600 clks");
    end
    chg = $urandom_range(5, 500);
    for (int p = 0; p < 2; p++) begin
      cnt_hi = pwm_out[0][0] ? 1 : 0;
      prev = pwm_out[0][0];
      edges = 0;
      found = 1'b0;
      for (int k = 1; k < 600 && !found; k++) begin
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
          checks++;
          if (pwm_out[g] !== exp_pwm[g] || period_start[g] !== exp_ps[g]) begin
            failures++;
            $display("FAIL mid_run dut%0d pwm=%h want %h", g, pwm_out[g],
                     exp_pwm[g]);
          end
        end
        if (p == 0 && k == chg) duty = 8'd192;
        if (period_start[0]) begin
          found = 1'b1;
        end else begin
          if (pwm_out[0][0]) cnt_hi++;
          if (pwm_out[0][0] != prev) edges++;
          prev = pwm_out[0][0];
        end
      end
      checks++;
      if (!found || cnt_hi != want[p] || edges != 1) begin
        failures++;
        $display("FAIL mid_period p=%0d high=%0d edges=%0d want %0d/1", p,
                 cnt_hi, edges, want[p]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    duty = 8'd200; en_out = '1; en_pwm = '1;
    for (int w = 0; w < 2; w++) begin
      found = 1'b0;
      for (int k = 0; k < 600 && !found; k++) begin
        @(negedge clk);
        found = period_start[0];
      end
    end
    repeat ($urandom_range(10, 300)) @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (pwm_out[0] !== 16'hFFFF) begin
      failures++;
      $display("FAIL rmid_pre pwm=%h want ffff", pwm_out[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (pwm_out[g] !== 16'h0 || period_start[g] !== 1'b0) begin
        failures++;
        $display("FAIL rmid_async dut%0d pwm=%h ps=%b want 0000/0", g,
                 pwm_out[g], period_start[g]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int g = 0; g < 2; g++) begin
      hi[g] = 0;
      pidx[g] = 0;
    end
    for (int k = 0; k < 2 * 512 + 8; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (pwm_out[g] !== exp_pwm[g] || period_start[g] !== exp_ps[g]) begin
          failures++;
          $display("FAIL rmid_run dut%0d k=%0d pwm=%h want %h", g, k,
                   pwm_out[g], exp_pwm[g]);
        end
        if (period_start[g]) begin
          checks++;
          if (hi[g] != (pidx[g] == 0 ? 0 : 200 * P[g])) begin
            failures++;
            $display("FAIL rmid_high dut%0d period=%0d got=%0d want=%0d", g,
                     pidx[g], hi[g], pidx[g] == 0 ? 0 : 200 * P[g]);
          end
          hi[g] = 0;
          pidx[g]++;
        end
        if (pwm_out[g][0]) hi[g]++;
      end
    end
    checks++;
    if (pidx[0] != 2) begin
      failures++;
      $display("FAIL rmid_periods got=%0d want=2", pidx[0]);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      duty = 8'($urandom);
      en_out = 16'($urandom);
      en_pwm = 16'($urandom);
      repeat ($urandom_range(50, 700)) begin
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
          checks++;
          if (pwm_out[g] !== exp_pwm[g] || period_start[g] !== exp_ps[g]) begin
            failures++;
            $display("FAIL rand_run dut%0d duty=%0d pwm=%h ps=%b want %h/%b",
                     g, duty, pwm_out[g], period_start[g], exp_pwm[g],
                     exp_ps[g]);
          end
        end
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_static();
    test_duty_half();
    test_extremes();
    test_mid_change();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
